// File: rtl/div8_pkg.sv
// rtl/div8_pkg.sv - shared states and sizing for the sequential restoring divider
package div8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div8_step.sv
// rtl/div8_step.sv - one combinational restoring shift-subtract step
module div8_step
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_full;
  logic [WIDTH+1:0] w_diff;

  assign w_full = {i_rem, i_bit};
  assign w_diff = w_full - {2'b00, i_dvs};

  // The borrow out of the subtraction is the "less than divisor" flag.
  assign o_qbit = ~w_diff[WIDTH+1];
  assign o_rem  = o_qbit ? w_diff[WIDTH:0] : w_full[WIDTH:0];

endmodule

// File: rtl/div8_2.sv
// rtl/div8_2.sv - sequential unsigned divider, one quotient bit per clock
module div8_2
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;
  logic             r_zpend;
  logic [WIDTH:0]   w_rem;
  logic             w_qbit;

  div8_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = (i_b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        // A divide-by-zero spends one cycle in DONE publishing results first.
        if (r_zpend) begin
          w_state_next = DONE;
        end else if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = (i_b == '0) ? DONE : RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zpend <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_dvd <= i_a;
        r_dvs <= i_b;
        r_rem <= '0;
        r_cnt <= '0;
        if (i_b == '0) begin
          r_zpend <= 1'b1;
        end else begin
          r_busy <= 1'b1;
          r_dbz  <= 1'b0;
        end
      end else if (r_state == RUN) begin
        r_rem <= w_rem;
        r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= {r_dvd[WIDTH-2:0], w_qbit};
          r_remo <= w_rem[WIDTH-1:0];
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (r_zpend) begin
        r_quot  <= '1;
        r_remo  <= r_dvd;
        r_dbz   <= 1'b1;
        r_zpend <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_quotient    = r_quot;
  assign o_remainder   = r_remo;
  assign o_div_by_zero = r_dbz;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
